// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronises level sources, latches rising edges as pending,
// masks them and hands the lowest-index eligible source to the control FSM.
module intr_ctrl #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               csr_mie,
    input  logic               int_taken,
    input  logic               mret_exec,
    input  logic               reg_we,
    input  logic               reg_addr,
    input  logic [NUM_SRC-1:0] reg_wdata,
    output logic [NUM_SRC-1:0] reg_rdata,
    output logic               INTR,
    output logic [ID_W-1:0]    int_id,
    output logic               in_service
);

    localparam int unsigned VLD_W = 3;

    logic [NUM_SRC-1:0] r_s1;
    logic [NUM_SRC-1:0] r_s2;
    logic [NUM_SRC-1:0] r_s3;
    logic [VLD_W-1:0]   r_vld;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [ID_W-1:0]    r_int_id;
    logic               r_in_service;

    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_win_oh;
    logic [NUM_SRC-1:0] w_take_clr;
    logic [NUM_SRC-1:0] w_w1c_clr;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic [ID_W-1:0]    w_win_id;
    logic               w_take;

    // r_vld marks when s3 holds a real post-reset sample, so a level already
    // high across reset is seen as held rather than as a fresh edge.
    assign w_edge     = r_s2 & ~r_s3 & {NUM_SRC{r_vld[VLD_W-1]}};
    assign w_eligible = r_pending & r_mask;
    assign w_take     = int_taken & (|w_eligible);

    // Lowest set bit of eligible wins (bit 0 highest priority).
    assign w_win_oh = w_eligible & (~w_eligible + NUM_SRC'(1));

    always_comb begin
        w_win_id = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (w_win_oh[i]) begin
                w_win_id = ID_W'(i);
            end
        end
    end

    // New edges beat both clear sources on the same bit.
    assign w_take_clr    = w_take ? w_win_oh : '0;
    assign w_w1c_clr     = (reg_we && reg_addr) ? reg_wdata : '0;
    assign w_pending_nxt = (r_pending & ~w_take_clr & ~w_w1c_clr) | w_edge;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1         <= '0;
            r_s2         <= '0;
            r_s3         <= '0;
            r_vld        <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_int_id     <= '0;
            r_in_service <= 1'b0;
        end else begin
            r_s1      <= irq_in;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_vld     <= {r_vld[VLD_W-2:0], 1'b1};
            r_pending <= w_pending_nxt;
            if (reg_we && !reg_addr) begin
                r_mask <= reg_wdata;
            end
            if (w_take) begin
                r_int_id     <= w_win_id;
                r_in_service <= 1'b1;
            end else if (mret_exec) begin
                r_in_service <= 1'b0;
            end
        end
    end

    assign INTR       = csr_mie & ~r_in_service & (|w_eligible);
    assign int_id     = r_int_id;
    assign in_service = r_in_service;
    assign reg_rdata  = reg_addr ? r_pending : r_mask;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: expectations are queued as stimulus is applied
// and popped against DUT outputs sampled 1ns after the active edge.
module tb_intr_ctrl;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned ID_W    = 2;

    logic               CLK;
    logic               RST;
    logic [NUM_SRC-1:0] irq_in;
    logic               csr_mie;
    logic               int_taken;
    logic               mret_exec;
    logic               reg_we;
    logic               reg_addr;
    logic [NUM_SRC-1:0] reg_wdata;
    logic [NUM_SRC-1:0] reg_rdata;
    logic               INTR;
    logic [ID_W-1:0]    int_id;
    logic               in_service;

    intr_ctrl #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .irq_in     (irq_in),
        .csr_mie    (csr_mie),
        .int_taken  (int_taken),
        .mret_exec  (mret_exec),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .INTR       (INTR),
        .int_id     (int_id),
        .in_service (in_service)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic pop(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0h with no expected value", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic wr(input logic addr, input logic [NUM_SRC-1:0] data);
        reg_we    = 1'b1;
        reg_addr  = addr;
        reg_wdata = data;
        step();
        reg_we    = 1'b0;
        reg_wdata = '0;
    endtask

    task automatic rd(input logic addr, output logic [31:0] val);
        reg_addr = addr;
        #1;
        val = 32'(reg_rdata);
    endtask

    logic [31:0] v;

    initial begin
        RST = 1'b1; irq_in = '0; csr_mie = 1'b0; int_taken = 1'b0; mret_exec = 1'b0;
        reg_we = 1'b0; reg_addr = 1'b0; reg_wdata = '0;

        // Reset state
        push("rst_intr", 0); push("rst_id", 0); push("rst_insvc", 0);
        push("rst_mask", 0); push("rst_pend", 0);
        steps(2);
        pop(32'(INTR)); pop(32'(int_id)); pop(32'(in_service));
        rd(1'b0, v); pop(v); rd(1'b1, v); pop(v);
        RST = 1'b0;
        steps(4);

        // Basic flow
        csr_mie = 1'b1;
        push("basic_mask", 32'h2);
        wr(1'b0, 4'b0010);
        rd(1'b0, v); pop(v);
        irq_in = 4'b0010;
        push("basic_pend_e2", 0); push("basic_intr_e2", 0);
        push("basic_pend_e3", 32'h2); push("basic_intr_e3", 1);
        steps(2);
        rd(1'b1, v); pop(v); pop(32'(INTR));
        step();
        rd(1'b1, v); pop(v); pop(32'(INTR));
        irq_in = '0;
        int_taken = 1'b1;
        push("basic_id", 1); push("basic_pend_tk", 0); push("basic_insvc", 1); push("basic_intr_tk", 0);
        step();
        int_taken = 1'b0;
        pop(32'(int_id)); rd(1'b1, v); pop(v); pop(32'(in_service)); pop(32'(INTR));
        mret_exec = 1'b1;
        push("basic_mret", 0);
        step();
        mret_exec = 1'b0;
        pop(32'(in_service));

        // Fixed priority
        wr(1'b0, 4'hF);
        irq_in = 4'b1001;
        push("prio_pend", 32'h9); push("prio_intr", 1);
        steps(3);
        rd(1'b1, v); pop(v); pop(32'(INTR));
        irq_in = '0;
        int_taken = 1'b1;
        push("prio_id0", 0); push("prio_pend_tk", 32'h8); push("prio_intr_tk", 0); push("prio_intr_hold", 0);
        step();
        int_taken = 1'b0;
        pop(32'(int_id)); rd(1'b1, v); pop(v); pop(32'(INTR));
        step();
        pop(32'(INTR));
        mret_exec = 1'b1;
        push("prio_intr_mret", 1);
        step();
        mret_exec = 1'b0;
        pop(32'(INTR));
        int_taken = 1'b1;
        push("prio_id3", 3); push("prio_pend_empty", 0);
        step();
        int_taken = 1'b0;
        pop(32'(int_id)); rd(1'b1, v); pop(v);
        mret_exec = 1'b1;
        step();
        mret_exec = 1'b0;

        // int_taken with nothing eligible is ignored
        int_taken = 1'b1;
        push("idle_take_id", 3); push("idle_take_insvc", 0);
        step();
        int_taken = 1'b0;
        pop(32'(int_id)); pop(32'(in_service));

        // Masking and global enable
        wr(1'b0, 4'h0);
        irq_in = 4'b0100;
        push("mask_pend_raw", 32'h4); push("mask_intr", 0);
        steps(3);
        irq_in = '0;
        rd(1'b1, v); pop(v); pop(32'(INTR));
        csr_mie = 1'b0;
        push("mie0_intr", 0);
        wr(1'b0, 4'hF);
        pop(32'(INTR));
        csr_mie = 1'b1;
        push("mie1_intr", 1);
        #1;
        pop(32'(INTR));

        // W1C colliding with a new edge on the same source
        irq_in = 4'b0100;
        steps(2);
        push("w1c_collide", 32'h4);
        wr(1'b1, 4'b0100);
        rd(1'b1, v); pop(v);
        push("w1c_clear", 0);
        wr(1'b1, 4'b0100);
        rd(1'b1, v); pop(v);
        push("held_level", 0);
        steps(4);
        rd(1'b1, v); pop(v);
        irq_in = '0;

        // int_taken and mret_exec in the same cycle
        irq_in = 4'b0001;
        push("both_pend", 32'h1);
        steps(3);
        rd(1'b1, v); pop(v);
        int_taken = 1'b1; mret_exec = 1'b1;
        push("both_insvc", 1); push("both_id", 0);
        step();
        int_taken = 1'b0; mret_exec = 1'b0;
        pop(32'(in_service)); pop(32'(int_id));

        // New edge beats an int_taken clear of the same bit
        irq_in = '0;
        steps(3);
        irq_in = 4'b0001;
        steps(3);
        irq_in = '0;
        steps(3);
        irq_in = 4'b0001;
        steps(2);
        int_taken = 1'b1;
        push("take_collide_pend", 32'h1); push("take_collide_id", 0);
        step();
        int_taken = 1'b0;
        rd(1'b1, v); pop(v); pop(32'(int_id));

        // Reset mid-service with everything pending and sources held high
        irq_in = '0;
        steps(3);
        irq_in = 4'hF;
        push("pre_rst_pend", 32'hF); push("pre_rst_insvc", 1);
        steps(3);
        rd(1'b1, v); pop(v); pop(32'(in_service));
        RST = 1'b1;
        push("post_rst_intr", 0); push("post_rst_insvc", 0); push("post_rst_id", 0);
        push("post_rst_pend", 0); push("post_rst_mask", 0);
        step();
        RST = 1'b0;
        pop(32'(INTR)); pop(32'(in_service)); pop(32'(int_id));
        rd(1'b1, v); pop(v); rd(1'b0, v); pop(v);
        wr(1'b0, 4'hF);
        push("rst_held_pend", 0); push("rst_held_intr", 0);
        steps(6);
        rd(1'b1, v); pop(v); pop(32'(INTR));
        irq_in = '0;
        steps(3);
        irq_in = 4'hF;
        push("rst_rearm_pend", 32'hF); push("rst_rearm_intr", 1);
        steps(3);
        rd(1'b1, v); pop(v); pop(32'(INTR));

        n_checks++;
        assert (q.size() == 0) n_pass++;
        else $error("FAIL scoreboard_leftover: observed %0d entries expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
